// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, opcode width
// and the control FSM state encoding.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_NOT  = 4'd5;
  localparam logic [OP_W-1:0] OP_SHL  = 4'd6;
  localparam logic [OP_W-1:0] OP_SHR  = 4'd7;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd8;
  localparam logic [OP_W-1:0] OP_MOVA = 4'd9;
  localparam logic [OP_W-1:0] OP_MOVB = 4'd10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MBUSY = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        load operands (ignored while busy)
//   a, b         multiplicand / multiplier, WIDTH bits
//   busy         iteration in progress
//   done         high during the final iteration cycle; prod is valid then
//   prod         2*WIDTH-bit product (combinational, includes the current step)
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic [2*WIDTH-1:0] addend;

  assign addend = mplier_q[0] ? mcand_q : '0;
  // The product including this cycle's step lets the caller capture the
  // result on the very edge that retires the last iteration.
  assign prod   = acc_q + addend;
  assign busy   = busy_q;
  assign done   = busy_q & (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start && !busy_q) begin
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= prod;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked ALU: single-cycle logic/arith/shift ops, WIDTH-cycle iterative MUL.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   issue handshake; a, b, op captured on accept
//   out_valid / out_ready writeback handshake; y, carry, zero, err held until taken
module alu_seq_core
  import alu_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  state_e             state_q;
  logic [WIDTH-1:0]   y_q;
  logic               carry_q;
  logic               zero_q;
  logic               err_q;
  logic               out_valid_q;

  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [SH_W-1:0]    sh;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     shl_w;
  logic [WIDTH:0]     shr_w;
  logic [WIDTH-1:0]   alu_y;
  logic               alu_c;
  logic               alu_err;

  // mul_busy is redundant with the state check; it keeps a stray issue out of
  // the multiplier should the two ever disagree.
  assign in_ready  = ((state_q == IDLE) | ((state_q == DONE) & out_ready)) & ~mul_busy;
  assign accept    = in_valid & in_ready;
  assign mul_start = accept & (op == OP_MUL);

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign err       = err_q;

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk  (clk),
    .rst_n(rst_n),
    .start(mul_start),
    .a    (a),
    .b    (b),
    .busy (mul_busy),
    .done (mul_done),
    .prod (mul_prod)
  );

  // Shifts are done one bit wider so the extra bit is the last bit shifted
  // out, and naturally 0 for a zero shift amount.
  assign sh    = b[SH_W-1:0];
  assign add_w = {1'b0, a} + {1'b0, b};
  assign shl_w = {1'b0, a} << sh;
  assign shr_w = {a, 1'b0} >> sh;

  always_comb begin
    alu_y   = '0;
    alu_c   = 1'b0;
    alu_err = 1'b0;
    case (op)
      OP_ADD: begin
        alu_y = add_w[WIDTH-1:0];
        alu_c = add_w[WIDTH];
      end
      OP_SUB: begin
        alu_y = a - b;
        alu_c = (a < b);
      end
      OP_AND:  alu_y = a & b;
      OP_OR:   alu_y = a | b;
      OP_XOR:  alu_y = a ^ b;
      OP_NOT:  alu_y = ~a;
      OP_SHL: begin
        alu_y = shl_w[WIDTH-1:0];
        alu_c = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_y = shr_w[WIDTH:1];
        alu_c = shr_w[0];
      end
      OP_MUL:  alu_y = '0;  // result comes from u_mul
      OP_MOVA: alu_y = a;
      OP_MOVB: alu_y = b;
      default: alu_err = 1'b1;
    endcase
  end

  // Control FSM with registered results; outputs change only on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      y_q         <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      if (op == OP_MUL) begin
        state_q     <= MBUSY;
        out_valid_q <= 1'b0;
      end else begin
        state_q     <= DONE;
        out_valid_q <= 1'b1;
        y_q         <= alu_y;
        carry_q     <= alu_c;
        zero_q      <= (alu_y == '0);
        err_q       <= alu_err;
      end
    end else begin
      unique case (state_q)
        MBUSY: begin
          if (mul_done) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            y_q         <= mul_prod[WIDTH-1:0];
            carry_q     <= |mul_prod[2*WIDTH-1:WIDTH];
            zero_q      <= (mul_prod[WIDTH-1:0] == '0);
            err_q       <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed self-checking bench for alu_seq_core at WIDTH=32.
module tb_alu_seq_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        carry;
  logic        zero;
  logic        err;

  int checks = 0;
  int fails  = 0;
  int edges;
  int lows;

  always #5 clk = ~clk;

  alu_seq_core #(
    .WIDTH(32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .carry    (carry),
    .zero     (zero),
    .err      (err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op, then wait (bounded) for out_valid. ed = edges after the
  // accept edge at which out_valid was seen; lw = samples with in_ready low
  // while the result was pending.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tbv, input logic [3:0] top,
                       output int ed, output int lw);
    int guard;
    @(negedge clk);
    a        = ta;
    b        = tbv;
    op       = top;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("issue_ready", in_ready, 1);
    @(posedge clk);
    #1;
    // Scramble inputs: captured values must not follow them.
    in_valid = 1'b0;
    a        = ~ta;
    b        = ~tbv;
    op       = 4'd0;
    ed       = 0;
    lw       = 0;
    while (!out_valid && ed < 100) begin
      if (!in_ready) lw++;
      @(posedge clk);
      #1;
      ed++;
    end
    if (!out_valid) check("result_timeout", out_valid, 1);
  endtask

  task automatic check_res(input string tag, input logic [31:0] ey, input logic ec,
                           input logic ez, input logic ee);
    check({tag, "_y"}, y, ey);
    check({tag, "_carry"}, carry, ec);
    check({tag, "_zero"}, zero, ez);
    check({tag, "_err"}, err, ee);
  endtask

  initial begin
    logic [31:0] exp1 [5];
    int seen;
    exp1[0] = 32'd88; exp1[1] = 32'd24; exp1[2] = 32'd32; exp1[3] = 32'd56; exp1[4] = 32'd24;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op        = '0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check_res("rst", 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back single-cycle ops, one result per cycle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a        = 32'd56;
      b        = 32'd32;
      op       = 4'(i);
      in_valid = 1'b1;
      check($sformatf("b2b_ready_%0d", i), in_ready, 1);
      @(posedge clk);
      #1;
      check($sformatf("b2b_valid_%0d", i), out_valid, 1);
      check($sformatf("b2b_y_%0d", i), y, exp1[i]);
      check($sformatf("b2b_carry_%0d", i), carry, 0);
    end
    in_valid = 1'b0;

    // Multiplies: fixed WIDTH-edge latency, in_ready low throughout.
    do_op(32'd56, 32'd32, 4'd8, edges, lows);
    check("mul_latency", edges, 32);
    check("mul_busy_cycles", lows, 32);
    check_res("mul_56x32", 32'd1792, 1'b0, 1'b0, 1'b0);
    do_op(32'h8000_0000, 32'd2, 4'd8, edges, lows);
    check_res("mul_ovf", 32'd0, 1'b1, 1'b1, 1'b0);
    do_op(32'd56, 32'd0, 4'd8, edges, lows);
    check("mul0_latency", edges, 32);
    check_res("mul_by0", 32'd0, 1'b0, 1'b1, 1'b0);

    // Arithmetic boundaries.
    do_op(32'hFFFF_FFFF, 32'd1, 4'd0, edges, lows);
    check("add_latency", edges, 0);
    check_res("add_wrap", 32'd0, 1'b1, 1'b1, 1'b0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0, edges, lows);
    check_res("add_ones", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    do_op(32'd5, 32'd7, 4'd1, edges, lows);
    check_res("sub_borrow", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    do_op(32'h0000_00F0, 32'd0, 4'd5, edges, lows);
    check_res("not", 32'hFFFF_FF0F, 1'b0, 1'b0, 1'b0);

    // Shifts.
    do_op(32'd56, 32'd2, 4'd6, edges, lows);
    check_res("shl2", 32'd224, 1'b0, 1'b0, 1'b0);
    do_op(32'd56, 32'd4, 4'd7, edges, lows);
    check_res("shr4", 32'd3, 1'b1, 1'b0, 1'b0);
    do_op(32'd56, 32'd32, 4'd6, edges, lows);
    check_res("shl0", 32'd56, 1'b0, 1'b0, 1'b0);

    // out_ready with nothing pending changes nothing.
    repeat (2) @(posedge clk);
    #1;
    check("idle_valid", out_valid, 0);
    check("idle_y_hold", y, 32'd56);

    // Backpressure: result held, new request refused.
    out_ready = 1'b0;
    do_op(32'd56, 32'd1, 4'd9, edges, lows);
    in_valid = 1'b1;
    a        = 32'd1;
    b        = 32'd1;
    op       = 4'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall_valid_%0d", i), out_valid, 1);
      check($sformatf("stall_y_%0d", i), y, 32'd56);
      check($sformatf("stall_ready_%0d", i), in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    do_op(32'd56, 32'd32, 4'd12, edges, lows);
    check("illegal_latency", edges, 0);
    check_res("illegal", 32'd0, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of a multiply.
    @(negedge clk);
    a        = 32'd56;
    b        = 32'd32;
    op       = 4'd8;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_ready", in_ready, 1);
    check_res("abort", 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("abort_no_result", seen, 0);
    do_op(32'd3, 32'd4, 4'd0, edges, lows);
    check_res("post_abort_add", 32'd7, 1'b0, 1'b0, 1'b0);
    do_op(32'd56, 32'd32, 4'd8, edges, lows);
    check("post_abort_mul_lat", edges, 32);
    check_res("post_abort_mul", 32'd1792, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
